// File: rtl/vga_fb_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | work_pkg : shared types and defaults for the VGA framebuffer arbiter |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package work_pkg;

    localparam int FB_ADDR_W = 19;
    localparam int FB_DATA_W = 3;
    localparam int FB_SIZE   = 307200;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } fb_arb_st_t;

endpackage
`default_nettype wire

// File: rtl/vga_fb_wq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fb_wq : synchronous write-queue FIFO with occupancy output       |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module vga_fb_wq #(
    parameter int WIDTH = 22,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule
`default_nettype wire

// File: rtl/vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | vga_fb_arbiter : single-port framebuffer arbiter (scan-out / draw /  |
// | full-frame clear).  Rev 1.0                                          |
// +----------------------------------------------------------------------+
module vga_fb_arbiter #(
    parameter int ADDR_W   = work_pkg::FB_ADDR_W,
    parameter int DATA_W   = work_pkg::FB_DATA_W,
    parameter int FB_SIZE  = work_pkg::FB_SIZE,
    parameter int WQ_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        rd_req,
    input  logic [ADDR_W-1:0]           rd_addr,
    output logic [DATA_W-1:0]           rd_data,
    output logic                        rd_valid,
    input  logic                        wr_req,
    input  logic [ADDR_W-1:0]           wr_addr,
    input  logic [DATA_W-1:0]           wr_data,
    output logic                        wr_ready,
    input  logic                        clr_req,
    input  logic [DATA_W-1:0]           clr_color,
    output logic                        clr_busy,
    output logic                        mem_en,
    output logic                        mem_we,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_wdata,
    input  logic [DATA_W-1:0]           mem_rdata,
    output logic [$clog2(WQ_DEPTH):0]   wq_level
);

    import work_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_SIZE - 1);

    fb_arb_st_t               state;
    fb_arb_st_t               state_nx;
    logic [ADDR_W-1:0]        clr_cnt;
    logic [DATA_W-1:0]        clr_col;
    logic [ADDR_W-1:0]        addr_q;
    logic [DATA_W-1:0]        wdata_q;
    logic                     rd_p1;

    logic                     wq_full;
    logic                     wq_empty;
    logic                     wq_push;
    logic                     wq_pop;
    logic [ADDR_W+DATA_W-1:0] wq_head;

    logic                     rd_grant;
    logic                     clr_grant;
    logic                     acc_en;
    logic                     acc_we;
    logic [ADDR_W-1:0]        acc_addr;
    logic [DATA_W-1:0]        acc_wdata;

    // Grants are gated by reset so the RAM port goes quiet the instant reset asserts.
    assign rd_grant  = rd_req & reset;
    assign clr_grant = reset & ~rd_req & (state == CLEAR);
    assign wq_pop    = reset & ~rd_req & (state != CLEAR) & ~wq_empty;
    assign wr_ready  = ~wq_full & (state == IDLE);
    assign wq_push   = wr_req & wr_ready;
    assign clr_busy  = (state != IDLE);

    vga_fb_wq #(
        .WIDTH (ADDR_W + DATA_W),
        .DEPTH (WQ_DEPTH)
    ) u_wq (
        .clk       (clk),
        .rst_n     (reset),
        .push      (wq_push),
        .push_data ({wr_addr, wr_data}),
        .pop       (wq_pop),
        .head      (wq_head),
        .full      (wq_full),
        .empty     (wq_empty),
        .level     (wq_level)
    );

    always_comb begin
        acc_en    = 1'b0;
        acc_we    = 1'b0;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (rd_grant) begin
            acc_en   = 1'b1;
            acc_addr = rd_addr;
        end else if (clr_grant) begin
            acc_en    = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = clr_cnt;
            acc_wdata = clr_col;
        end else if (wq_pop) begin
            acc_en    = 1'b1;
            acc_we    = 1'b1;
            acc_addr  = wq_head[ADDR_W+DATA_W-1:DATA_W];
            acc_wdata = wq_head[DATA_W-1:0];
        end
    end

    assign mem_en    = acc_en;
    assign mem_we    = acc_we;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (clr_req) state_nx = DRAIN;
            DRAIN:   if (wq_empty) state_nx = CLEAR;
            CLEAR:   if (clr_grant && (clr_cnt == LAST_ADDR)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clr_cnt  <= '0;
            clr_col  <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rd_p1    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state    <= state_nx;
            addr_q   <= acc_addr;
            wdata_q  <= acc_wdata;
            rd_p1    <= rd_grant;
            rd_valid <= rd_p1;
            if (rd_p1) rd_data <= mem_rdata;
            if ((state == IDLE) && clr_req) clr_col <= clr_color;
            if (clr_grant) clr_cnt <= (clr_cnt == LAST_ADDR) ? '0 : clr_cnt + ADDR_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_fb_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_vga_fb_arbiter : directed bench for vga_fb_arbiter (FB_SIZE=16)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_vga_fb_arbiter;

    localparam int ADDR_W   = 19;
    localparam int DATA_W   = 3;
    localparam int FB_SIZE  = 16;
    localparam int WQ_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ready;
    logic              clr_req;
    logic [DATA_W-1:0] clr_color;
    logic              clr_busy;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [2:0]        wq_level;

    logic [2:0] ram     [0:255];
    logic       wr_seen [0:255];
    logic       ram_init;

    int checks = 0;
    int errors = 0;

    vga_fb_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FB_SIZE  (FB_SIZE),
        .WQ_DEPTH (WQ_DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .clr_req   (clr_req),
        .clr_color (clr_color),
        .clr_busy  (clr_busy),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wq_level  (wq_level)
    );

    always #5 clk = ~clk;

    // RAM model: address a holds a[2:0] after init, except 0x10 which holds 3'b101.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) begin
                ram[i]     <= 3'(i);
                wr_seen[i] <= 1'b0;
            end
            ram[16] <= 3'b101;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:0]]     <= mem_wdata;
                wr_seen[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= ram[mem_addr[7:0]];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_mem_en"},    32'(mem_en),    0);
        chk({tag, "_mem_we"},    32'(mem_we),    0);
        chk({tag, "_mem_addr"},  32'(mem_addr),  0);
        chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
        chk({tag, "_rd_valid"},  32'(rd_valid),  0);
        chk({tag, "_rd_data"},   32'(rd_data),   0);
        chk({tag, "_clr_busy"},  32'(clr_busy),  0);
        chk({tag, "_wq_level"},  32'(wq_level),  0);
    endtask

    initial begin
        reset     = 1'b0;
        ram_init  = 1'b1;
        rd_req    = 1'b1;
        rd_addr   = 19'h5;
        wr_req    = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        clr_req   = 1'b0;
        clr_color = '0;
        repeat (2) nxt();
        mid();
        chk_reset_outputs("rst");

        nxt();
        reset    = 1'b1;
        ram_init = 1'b0;
        rd_req   = 1'b0;
        mid();
        chk("rel_wr_ready", 32'(wr_ready), 1);

        // Single read: grant same cycle, data two cycles later.
        nxt();
        rd_req  = 1'b1;
        rd_addr = 19'h10;
        mid();
        chk("rd_mem_en",   32'(mem_en),   1);
        chk("rd_mem_we",   32'(mem_we),   0);
        chk("rd_mem_addr", 32'(mem_addr), 32'h10);
        nxt();
        rd_req = 1'b0;
        mid();
        chk("rd_n1_valid", 32'(rd_valid), 0);
        chk("idle_mem_en", 32'(mem_en),   0);
        chk("hold_addr",   32'(mem_addr), 32'h10);
        nxt();
        mid();
        chk("rd_n2_valid", 32'(rd_valid), 1);
        chk("rd_n2_data",  32'(rd_data),  5);
        nxt();
        mid();
        chk("rd_n3_valid", 32'(rd_valid), 0);

        // Eight back-to-back reads of 0x20..0x27.
        for (int k = 0; k < 12; k++) begin
            nxt();
            rd_req  = (k < 8);
            rd_addr = 19'(32'h20 + k);
            mid();
            if (k >= 2 && k < 10) begin
                chk("burst_valid", 32'(rd_valid), 1);
                chk("burst_data",  32'(rd_data),  32'(k - 2));
            end else begin
                chk("burst_novalid", 32'(rd_valid), 0);
            end
        end

        // Read priority over a queued write.
        nxt();
        rd_req  = 1'b1;
        rd_addr = 19'h30;
        wr_req  = 1'b1;
        wr_addr = 19'h20;
        wr_data = 3'b011;
        mid();
        chk("prio_wr_ready", 32'(wr_ready), 1);
        chk("prio_no_we0",   32'(mem_we),   0);
        chk("prio_addr0",    32'(mem_addr), 32'h30);
        for (int k = 1; k < 5; k++) begin
            nxt();
            wr_req = 1'b0;
            mid();
            chk("prio_no_we", 32'(mem_we),   0);
            chk("prio_level", 32'(wq_level), 1);
        end
        nxt();
        rd_req = 1'b0;
        mid();
        chk("prio_we",    32'(mem_we),    1);
        chk("prio_waddr", 32'(mem_addr),  32'h20);
        chk("prio_wdata", 32'(mem_wdata), 3);
        nxt();
        mid();
        chk("prio_level0", 32'(wq_level), 0);
        chk("prio_idle",   32'(mem_en),   0);

        // Fill the queue under read pressure, drop a fifth write, then drain.
        for (int k = 0; k < 4; k++) begin
            nxt();
            rd_req  = 1'b1;
            wr_req  = 1'b1;
            wr_addr = 19'(32'h40 + k);
            wr_data = 3'(4 + k);
            mid();
            chk("fill_level", 32'(wq_level), 32'(k));
        end
        nxt();
        wr_addr = 19'h44;
        wr_data = 3'b001;
        mid();
        chk("full_level", 32'(wq_level), 4);
        chk("full_ready", 32'(wr_ready), 0);
        for (int k = 0; k < 4; k++) begin
            nxt();
            rd_req = 1'b0;
            wr_req = 1'b0;
            mid();
            chk("drain_we",    32'(mem_we),    1);
            chk("drain_addr",  32'(mem_addr),  32'(32'h40 + k));
            chk("drain_data",  32'(mem_wdata), 32'(4 + k));
            chk("drain_level", 32'(wq_level),  32'(4 - k));
        end
        nxt();
        mid();
        chk("drained_level", 32'(wq_level), 0);
        chk("drained_idle",  32'(mem_en),   0);

        // Simultaneous push and pop keeps the level.
        nxt();
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 19'h60;
        wr_data = 3'b011;
        nxt();
        rd_req  = 1'b0;
        wr_addr = 19'h61;
        wr_data = 3'b100;
        mid();
        chk("pp_level_before", 32'(wq_level), 1);
        chk("pp_pop_addr",     32'(mem_addr), 32'h60);
        nxt();
        wr_req = 1'b0;
        mid();
        chk("pp_level_same", 32'(wq_level),  1);
        chk("pp_pop2_addr",  32'(mem_addr),  32'h61);
        chk("pp_pop2_data",  32'(mem_wdata), 4);
        nxt();
        mid();
        chk("pp_level0", 32'(wq_level), 0);

        // Clear with two writes queued.
        nxt();
        rd_req  = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 19'h50;
        wr_data = 3'b001;
        nxt();
        wr_addr = 19'h51;
        wr_data = 3'b010;
        nxt();
        rd_req    = 1'b0;
        wr_req    = 1'b0;
        clr_req   = 1'b1;
        clr_color = 3'b010;
        mid();
        chk("clr_idle_busy",  32'(clr_busy), 0);
        chk("clr_idle_level", 32'(wq_level), 2);
        chk("clr_idle_pop",   32'(mem_addr), 32'h50);
        nxt();
        clr_color = 3'b101;
        mid();
        chk("drain1_busy",  32'(clr_busy), 1);
        chk("drain1_ready", 32'(wr_ready), 0);
        chk("drain1_addr",  32'(mem_addr), 32'h51);
        chk("drain1_we",    32'(mem_we),   1);
        nxt();
        clr_req = 1'b0;
        mid();
        chk("drain2_busy", 32'(clr_busy), 1);
        chk("drain2_idle", 32'(mem_en),   0);
        for (int k = 0; k < 16; k++) begin
            nxt();
            mid();
            chk("clr_we",   32'(mem_we),    1);
            chk("clr_addr", 32'(mem_addr),  32'(k));
            chk("clr_data", 32'(mem_wdata), 2);
            chk("clr_busy", 32'(clr_busy),  1);
        end
        nxt();
        mid();
        chk("clr_done_busy", 32'(clr_busy), 0);
        chk("clr_done_idle", 32'(mem_en),   0);

        // Clear with a read every other cycle: 32 CLEAR cycles.
        nxt();
        clr_req   = 1'b1;
        clr_color = 3'b110;
        mid();
        chk("clr2_idle_busy", 32'(clr_busy), 0);
        nxt();
        clr_req = 1'b0;
        mid();
        chk("clr2_drain_busy", 32'(clr_busy), 1);
        for (int j = 0; j < 32; j++) begin
            nxt();
            rd_req  = (j % 2 == 0);
            rd_addr = 19'h20;
            mid();
            if (j % 2 == 0) begin
                chk("ilv_rd_we",   32'(mem_we),   0);
                chk("ilv_rd_addr", 32'(mem_addr), 32'h20);
            end else begin
                chk("ilv_wr_we",   32'(mem_we),    1);
                chk("ilv_wr_addr", 32'(mem_addr),  32'((j - 1) / 2));
                chk("ilv_wr_data", 32'(mem_wdata), 6);
            end
            chk("ilv_busy", 32'(clr_busy), 1);
            if (j >= 2 && j % 2 == 0) begin
                chk("ilv_valid", 32'(rd_valid), 1);
                chk("ilv_data",  32'(rd_data),  3);
            end
        end
        nxt();
        rd_req = 1'b0;
        mid();
        chk("ilv_done_busy", 32'(clr_busy), 0);
        chk("ilv_last_valid", 32'(rd_valid), 1);
        chk("ilv_last_data",  32'(rd_data),  3);
        nxt();
        rd_req  = 1'b1;
        rd_addr = 19'h9;
        nxt();
        rd_req = 1'b0;
        nxt();
        mid();
        chk("readback_valid", 32'(rd_valid), 1);
        chk("readback_data",  32'(rd_data),  6);
        chk("dropped_write",  32'(wr_seen[8'h44]), 0);

        // Reset in the middle of a clear, with the counter at 7.
        nxt();
        ram_init = 1'b1;
        nxt();
        ram_init  = 1'b0;
        clr_req   = 1'b1;
        clr_color = 3'b111;
        nxt();
        clr_req = 1'b0;
        for (int k = 0; k < 7; k++) begin
            nxt();
            mid();
            chk("pre_rst_addr", 32'(mem_addr), 32'(k));
        end
        nxt();
        chk("pre_rst_busy", 32'(clr_busy), 1);
        chk("pre_rst_addr7", 32'(mem_addr), 7);
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid_rst");
        nxt();
        nxt();
        reset = 1'b1;
        mid();
        chk("post_rst_ready", 32'(wr_ready), 1);
        chk("post_rst_busy",  32'(clr_busy), 0);
        repeat (20) nxt();
        mid();
        for (int i = 0; i < 16; i++) begin
            chk("rst_written", 32'(wr_seen[i]), (i < 7) ? 1 : 0);
        end
        chk("rst_ram3", 32'(ram[3]), 7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vga_fb_arbiter.md
VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

Interface
REQ-001 Parameters (name, default, meaning):
- ADDR_W, 19, framebuffer address width.
- DATA_W, 3, pixel width ({r,g,b}).
- FB_SIZE, 307200, framebuffer word count (640x480).
- WQ_DEPTH, 4, write-queue entries (power of 2).

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock.
- reset, in, 1, asynchronous active-low reset.
- rd_req, in, 1, scan-out pixel request.
- rd_addr, in, ADDR_W, scan-out address.
- rd_data, out, DATA_W, returned pixel.
- rd_valid, out, 1, rd_data strobe.
- wr_req, in, 1, draw-port write request.
- wr_addr, in, ADDR_W, draw write address.
- wr_data, in, DATA_W, draw write pixel.
- wr_ready, out, 1, draw port can accept.
- clr_req, in, 1, start full-frame clear (pulse).
- clr_color, in, DATA_W, clear pixel value.
- clr_busy, out, 1, clear sequence in progress.
- mem_en, out, 1, RAM enable.
- mem_we, out, 1, RAM write enable.
- mem_addr, out, ADDR_W, RAM address.
- mem_wdata, out, DATA_W, RAM write data.
- mem_rdata, in, DATA_W, RAM read data (1-cycle latency).
- wq_level, out, $clog2(WQ_DEPTH)+1, queue occupancy.

Function
REQ-003 One RAM access per cycle; priority: rd_req > clear/queue write.
REQ-004 rd_req in cycle N SHALL drive mem_en=1, mem_we=0, mem_addr=rd_addr in cycle N (combinational grant).
REQ-005 rd_data SHALL be registered from mem_rdata, with rd_valid=1 in cycle N+2 only; back-to-back rd_req SHALL be serviced every cycle.
REQ-006 Draw writes are pushed into the write queue when wr_req & wr_ready; wr_ready = !full & state==IDLE.
REQ-007 No bypass: a write pushed in cycle N reaches RAM no earlier than N+1.
REQ-008 Queue head pops to RAM (mem_we=1) in any cycle with no rd_req, state!=CLEAR, and queue non-empty.
REQ-009 Push and pop in the same cycle leave wq_level unchanged; when the queue is full, wr_ready=0 and wr_req is ignored.
REQ-010 FSM states IDLE, DRAIN, CLEAR:
- IDLE -> DRAIN on clr_req.
- DRAIN -> CLEAR when the queue is empty (same cycle if already empty).
- CLEAR -> IDLE after writing address FB_SIZE-1.
REQ-011 clr_color SHALL be latched on clr_req acceptance in IDLE; clr_req is ignored outside IDLE.
REQ-012 In CLEAR, a counter from 0 writes the latched color at counter address in every cycle with no rd_req, then increments; it never exceeds FB_SIZE-1.
REQ-013 clr_busy=1 in DRAIN and CLEAR.
REQ-014 When no access is granted: mem_en=0, mem_we=0; mem_addr/mem_wdata hold last value.

Reset
REQ-015 reset low SHALL asynchronously force:
- FSM=IDLE, queue empty, clear counter=0.
- rd_valid=0, rd_data=0, clr_busy=0, wq_level=0.
- mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
REQ-016 Reset mid-clear SHALL abandon the clear with no resume; queued writes are discarded.
REQ-017 After reset release, wr_ready=1 in the first cycle.

Structure
REQ-018 The work_pkg package holds:
- The FSM state enum (fb_arb_st_t: IDLE, DRAIN, CLEAR).
- Default constants FB_ADDR_W, FB_DATA_W, FB_SIZE.
REQ-019 The write queue SHALL be a sub-module vga_fb_wq (synchronous FIFO with level output); the arbiter and FSM stay in vga_fb_arbiter.

Verification
REQ-020 Read latency: rd_req with rd_addr=0x00010, RAM preloaded 3'b101 -> rd_valid and rd_data=3'b101 two cycles later; rd_req every cycle for 8 cycles -> 8 consecutive rd_valid.
REQ-021 Priority: queue holds 1 write (addr 0x00020, data 3'b011), rd_req high 5 cycles -> no mem_we for 5 cycles, write issued in the 6th cycle.
REQ-022 Full queue: 4 writes pushed while rd_req held -> wq_level=4, wr_ready=0; 5th wr_req dropped; releasing rd_req drains the queue in 4 cycles in order.
REQ-023 Clear: clr_req with clr_color=3'b010 and 2 writes queued -> DRAIN 2 cycles, then CLEAR writes addresses 0..FB_SIZE-1 (use FB_SIZE=16 bench override) with 3'b010; clr_busy falls the cycle after address 15.
REQ-024 Clear with interleaved rd_req every 2nd cycle -> clear takes 32 cycles for FB_SIZE=16; reads return correct data throughout.
REQ-025 Reset asserted at clear counter=7 -> all outputs at reset values immediately; after release FSM=IDLE, wr_ready=1, and addresses 7..15 remain unwritten.
